digit_serial_adder: RTL and testbench

- Multi-cycle, parametrised successor to the single-bit full adder.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, using one DIGIT-wide full-adder slice and a registered carry.
- Adds a start/busy/done handshake, a subtract mode and a signed-overflow flag.
- Arithmetic leaf for area-constrained datapaths where latency is acceptable.

---
 rtl/digit_serial_adder_if.sv | 26 ++
 rtl/digit_serial_adder.sv | 111 +++++++++++
 tb/tb_digit_serial_adder.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/digit_serial_adder_if.sv
// Operand/result bundle for the digit-serial adder: request side drives operands,
// the adder returns status and results.
interface digit_serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract: one DIGIT-wide adder slice and a registered carry walk
// WIDTH-bit operands LSB first, WIDTH/DIGIT cycles per operation.
module digit_serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input logic                clk,
  input logic                rst,
  digit_serial_adder_if.slave bus
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SW = DIGIT + 1;

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("digit_serial_adder: DIGIT must be >= 1 and divide WIDTH exactly");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             sa_q;
  logic             sb_q;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;
  logic             ovf_q;

  logic [SW-1:0]          slice_c;
  logic [WIDTH+DIGIT-1:0] sum_cat_c;
  logic [WIDTH-1:0]       sum_next_c;
  logic                   last_c;

  // Adder slice on the low digit; its sum enters the result register from the top.
  assign slice_c    = SW'(a_q[DIGIT-1:0]) + SW'(b_q[DIGIT-1:0]) + SW'(carry_q);
  assign sum_cat_c  = {slice_c[DIGIT-1:0], sum_q};
  assign sum_next_c = sum_cat_c[WIDTH+DIGIT-1:DIGIT];
  assign last_c     = (cnt_q == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            // Subtraction is a + ~b + 1, so cin is replaced by the forced 1.
            a_q     <= bus.a;
            b_q     <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub ? 1'b1 : bus.cin;
            sa_q    <= bus.a[WIDTH-1];
            sb_q    <= bus.sub ? ~bus.b[WIDTH-1] : bus.b[WIDTH-1];
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          sum_q   <= sum_next_c;
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          carry_q <= slice_c[DIGIT];
          cnt_q   <= cnt_q + CW'(1);
          if (last_c) begin
            cout_q  <= slice_c[DIGIT];
            ovf_q   <= (sa_q == sb_q) && (sum_next_c[WIDTH-1] != sa_q);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed and random checks of two digit-serial adder instances (DIGIT=1 and DIGIT=4)
// against an integer-arithmetic reference.
module tb_digit_serial_adder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  digit_serial_adder_if #(.WIDTH(8)) bus1 ();
  digit_serial_adder_if #(.WIDTH(8)) bus4 ();

  digit_serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  digit_serial_adder #(.WIDTH(8), .DIGIT(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view {busy, done, ovf, cout, sum}.
  function automatic logic [11:0] obs(int sel);
    if (sel == 1) return {bus1.busy, bus1.done, bus1.ovf, bus1.cout, bus1.sum};
    else          return {bus4.busy, bus4.done, bus4.ovf, bus4.cout, bus4.sum};
  endfunction

  // Reference result {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [9:0] model(logic [7:0] a, logic [7:0] b, logic ci, logic su);
    int ua, ub, sa, sb, full, sres;
    logic co, ov;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (su) begin
      full = ua - ub;
      co   = (ua >= ub);
      sres = sa - sb;
    end else begin
      full = ua + ub + int'(ci);
      co   = (full > 255);
      sres = sa + sb + int'(ci);
    end
    ov = (sres > 127) || (sres < -128);
    return {ov, co, 8'(full)};
  endfunction

  task automatic chk(string tag, logic [11:0] o, logic [11:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic drive(int sel, logic st, logic [7:0] a, logic [7:0] b, logic ci, logic su);
    if (sel == 1) begin
      bus1.start = st; bus1.a = a; bus1.b = b; bus1.cin = ci; bus1.sub = su;
    end else begin
      bus4.start = st; bus4.a = a; bus4.b = b; bus4.cin = ci; bus4.sub = su;
    end
  endtask

  // One operation with full timing check; hold=1 keeps start high with other operands.
  task automatic do_op(string tag, int sel, logic [7:0] a, logic [7:0] b, logic ci, logic su,
                       logic hold);
    int n;
    logic [9:0] exp;
    n   = (sel == 1) ? 8 : 2;
    exp = model(a, b, ci, su);
    drive(sel, 1'b1, a, b, ci, su);
    @(posedge clk);
    @(negedge clk);
    if (hold) drive(sel, 1'b1, 8'hAA, 8'h55, ~ci, ~su);
    else      drive(sel, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    for (int k = 1; k <= n; k++) begin
      chk({tag, "_busy"}, 12'(obs(sel) >> 10), 12'b10);
      @(negedge clk);
    end
    chk({tag, "_done"}, obs(sel), {2'b01, exp});
    drive(sel, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    chk({tag, "_hold"}, obs(sel), {2'b00, exp});
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rc, rs;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    drive(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    drive(4, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_d1", obs(1), 12'h000);
    chk("reset_d4", obs(4), 12'h000);
    rst = 1'b0;
    @(negedge clk);

    do_op("ff_plus_01", 1, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    do_op("7f_plus_01", 1, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    do_op("05_minus_07", 1, 8'h05, 8'h07, 1'b1, 1'b1, 1'b0);
    do_op("busy_ignore", 1, 8'h10, 8'h20, 1'b0, 1'b0, 1'b1);
    do_op("80_minus_01", 1, 8'h80, 8'h01, 1'b0, 1'b1, 1'b0);
    do_op("7f_plus_00_c", 1, 8'h7F, 8'h00, 1'b1, 1'b0, 1'b0);

    // Reset in the 4th RUN cycle aborts with nothing retained.
    drive(1, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_clear", obs(1), 12'h000);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("abort_quiet", 12'(obs(1) >> 10), 12'b00);
    end
    do_op("after_abort", 1, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);

    do_op("d4_a5_5a", 4, 8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0);
    do_op("d4_sub", 4, 8'h10, 8'h80, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 12; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      do_op("rand_d1", 1, ra, rb, rc, rs, 1'($urandom));
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      do_op("rand_d4", 4, ra, rb, rc, rs, 1'($urandom));
    end

    // Start held high: one operation every N+2 = 4 cycles.
    drive(4, 1'b1, 8'h33, 8'h44, 1'b0, 1'b0);
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k % 4 == 3)      chk("b2b_done", obs(4), {2'b01, model(8'h33, 8'h44, 1'b0, 1'b0)});
      else if (k % 4 == 0) chk("b2b_idle", 12'(obs(4) >> 10), 12'b00);
      else                 chk("b2b_busy", 12'(obs(4) >> 10), 12'b10);
    end
    drive(4, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
